// File: rtl/uart_ip_pkg.sv
// Shared definitions for the uart_ip receive and transmit stages.
package uart_ip_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_OVERSAMPLE = 16;

    // Receiver FSM states; BRK parks the receiver while the line is held low.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK
    } rcvr_state_t;

    // Expected parity bit for a data word: even parity makes the total count of
    // ones even, odd parity makes it odd. Narrower words are zero-extended.
    function automatic logic parity_calc(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
module uart_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic arst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw input through STAGES flops; reset to the line's idle level.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rcvr.sv
// UART receive stage: oversampled majority-vote bit recovery, single-entry
// holding register and parity/framing/overrun error pulses.
module uart_rcvr
    import uart_ip_pkg::*;
#(
    parameter int DATA_W      = UART_DATA_W,
    parameter int OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              rcv_clk_en,
    input  logic              rx,
    input  logic              parity_en,
    input  logic              parity_odd,
    input  logic              stop2,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ack,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun_err,
    output logic              busy
);

    // Holding-register handshake: rx_valid is high while rx_data holds an unread
    // byte. A cycle with rx_valid=1 and rx_ack=1 is a transfer and clears rx_valid
    // on the next edge; rx_ack while rx_valid=0 has no effect. A new frame always
    // loads; if it lands on a full register without a transfer in the same cycle
    // the old byte is lost and overrun_err pulses.

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_W);

    localparam logic [TW-1:0] TICK_A    = TW'(OVERSAMPLE/2 - 1);
    localparam logic [TW-1:0] TICK_B    = TW'(OVERSAMPLE/2);
    localparam logic [TW-1:0] TICK_C    = TW'(OVERSAMPLE/2 + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

    rcvr_state_t       state_q, state_d;
    logic              rx_s, rx_prev;
    logic [TW-1:0]     tick_cnt;
    logic [BW-1:0]     bit_cnt;
    logic              samp_a, samp_b;
    logic [DATA_W-1:0] shift_q;
    logic              par_en_q, par_odd_q, stop2_q;
    logic              stop_cnt;
    logic              par_bad_q;
    logic              load_pend;
    logic              start_det, at_mid, at_last, maj;
    logic [7:0]        par_data;

    uart_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk  (clk),
        .arst (arst),
        .d    (rx),
        .q    (rx_s)
    );

    // Falling edge of the synchronized line, seen on a baud tick.
    assign start_det = rcv_clk_en & rx_prev & ~rx_s;
    // The mid-bit decision tick uses the live sample as the third vote.
    assign at_mid    = rcv_clk_en & (tick_cnt == TICK_C);
    assign at_last   = rcv_clk_en & (tick_cnt == TICK_LAST);
    assign maj       = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
    assign par_data  = 8'(shift_q);
    assign busy      = (state_q != IDLE);

    // State register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; every transition is qualified by a baud tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (start_det) state_d = START;
            START:  begin
                if (at_mid && maj) begin
                    state_d = IDLE;
                end else if (at_last) begin
                    state_d = DATA;
                end
            end
            DATA:   if (at_last && (bit_cnt == BIT_LAST)) state_d = par_en_q ? PARITY : STOP;
            PARITY: if (at_last) state_d = STOP;
            STOP:   begin
                if (at_mid) begin
                    if (!maj) begin
                        state_d = BRK;
                    end else if (!stop2_q || stop_cnt) begin
                        state_d = IDLE;
                    end
                end
            end
            BRK:    if (rcv_clk_en && rx_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters, sampling, shift register, holding register and error pulses.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rx_prev     <= 1'b1;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            samp_a      <= 1'b1;
            samp_b      <= 1'b1;
            shift_q     <= '0;
            par_en_q    <= 1'b0;
            par_odd_q   <= 1'b0;
            stop2_q     <= 1'b0;
            stop_cnt    <= 1'b0;
            par_bad_q   <= 1'b0;
            load_pend   <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;

            if (rx_valid && rx_ack) begin
                rx_valid <= 1'b0;
            end

            // The load takes priority over a same-cycle transfer: the consumer
            // took the old byte, the new one is now waiting.
            if (load_pend) begin
                load_pend   <= 1'b0;
                rx_data     <= shift_q;
                rx_valid    <= 1'b1;
                parity_err  <= par_bad_q;
                overrun_err <= rx_valid & ~rx_ack;
            end

            if (rcv_clk_en) begin
                rx_prev  <= rx_s;
                if (tick_cnt == TICK_A) samp_a <= rx_s;
                if (tick_cnt == TICK_B) samp_b <= rx_s;
                tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;

                case (state_q)
                    IDLE: begin
                        tick_cnt <= '0;
                        if (start_det) begin
                            par_en_q  <= parity_en;
                            par_odd_q <= parity_odd;
                            stop2_q   <= stop2;
                            bit_cnt   <= '0;
                            stop_cnt  <= 1'b0;
                            par_bad_q <= 1'b0;
                        end
                    end
                    DATA: begin
                        if (at_mid)  shift_q[bit_cnt] <= maj;
                        if (at_last) bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY: begin
                        if (at_mid) par_bad_q <= (maj != parity_calc(par_data, par_odd_q));
                    end
                    STOP: begin
                        if (at_mid) begin
                            if (!maj) begin
                                frame_err <= 1'b1;
                            end else if (!stop2_q || stop_cnt) begin
                                load_pend <= 1'b1;
                            end else begin
                                stop_cnt <= 1'b1;
                            end
                        end
                    end
                    BRK: tick_cnt <= '0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rcvr.sv
// Directed plus randomized frames against a frame-level model of the receiver.
module tb_uart_rcvr;

    localparam int DATA_W = 8;
    localparam int OS     = 16;
    localparam int SYNC   = 2;

    logic              clk = 1'b0;
    logic              arst, rcv_clk_en, rx, parity_en, parity_odd, stop2, rx_ack;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid, parity_err, frame_err, overrun_err, busy;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Pulse counters gathered by the monitor and the model's expected totals.
    int perr_cnt = 0, ferr_cnt = 0, oerr_cnt = 0;
    int exp_perr = 0, exp_ferr = 0, exp_oerr = 0;
    int rise_cyc = -1;
    logic valid_d = 1'b0;

    // Scoreboard: byte waiting in the holding register (at most one entry).
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] model_data = '0;

    uart_rcvr #(
        .DATA_W      (DATA_W),
        .OVERSAMPLE  (OS),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk         (clk),
        .arst        (arst),
        .rcv_clk_en  (rcv_clk_en),
        .rx          (rx),
        .parity_en   (parity_en),
        .parity_odd  (parity_odd),
        .stop2       (stop2),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ack      (rx_ack),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: count error pulses and note when rx_valid rises.
    always @(negedge clk) begin
        if (parity_err)  perr_cnt++;
        if (frame_err)   ferr_cnt++;
        if (overrun_err) oerr_cnt++;
        if (rx_valid && !valid_d) rise_cyc = cyc;
        valid_d = rx_valid;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Driver: one complete frame, LSB first, each bit OS clocks long.
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic po,
                              input logic s2, input logic bad_par, input logic bad_stop,
                              output int start_cyc);
        logic bits[$];
        bits = {};
        parity_en  = pe;
        parity_odd = po;
        stop2      = s2;
        bits.push_back(1'b0);
        for (int i = 0; i < DATA_W; i++) bits.push_back(d[i]);
        if (pe) bits.push_back((^d) ^ po ^ bad_par);
        bits.push_back(~bad_stop);
        if (s2) bits.push_back(1'b1);
        start_cyc = cyc;
        foreach (bits[i]) begin
            rx = bits[i];
            repeat (OS) @(negedge clk);
        end
    endtask

    // Model: a good frame arrives at the holding register.
    task automatic model_load(input logic [7:0] d, input logic bad_par, input logic ack_same);
        if (bad_par) exp_perr++;
        if (exp_q.size() != 0) begin
            if (!ack_same) exp_oerr++;
            exp_q.delete();
        end
        exp_q.push_back(d);
        model_data = d;
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        check($sformatf("%s_valid", tag), 32'(rx_valid), 32'(exp_q.size() != 0));
        check($sformatf("%s_data", tag), 32'(rx_data), 32'(model_data));
        check($sformatf("%s_perr", tag), perr_cnt, exp_perr);
        check($sformatf("%s_ferr", tag), ferr_cnt, exp_ferr);
        check($sformatf("%s_oerr", tag), oerr_cnt, exp_oerr);
    endtask

    task automatic check_reset_outputs(input string tag);
        check($sformatf("%s_data", tag), 32'(rx_data), 0);
        check($sformatf("%s_valid", tag), 32'(rx_valid), 0);
        check($sformatf("%s_perr", tag), 32'(parity_err), 0);
        check($sformatf("%s_ferr", tag), 32'(frame_err), 0);
        check($sformatf("%s_oerr", tag), 32'(overrun_err), 0);
        check($sformatf("%s_busy", tag), 32'(busy), 0);
    endtask

    // Directed and random sequence.
    initial begin
        int s0, s1, s2v, lat, lat1;
        logic [7:0] d;
        logic pe, po, st2, bp;

        arst = 1'b1; rcv_clk_en = 1'b1; rx = 1'b1; rx_ack = 1'b0;
        parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        arst = 1'b0;
        repeat (20) @(negedge clk);

        // 8N1 0xA5, including load latency relative to the start edge.
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s0);
        model_load(8'hA5, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check_state("a5");
        lat = rise_cyc - s0;
        // Stop-bit decision tick plus one load clock, allowing for input
        // synchronization and edge detection ahead of the first tick.
        check("a5_latency", 32'((lat >= 9*OS + OS/2 + 2) && (lat <= 9*OS + OS/2 + 2 + SYNC + 3)), 1);
        do_ack();
        check_state("a5_ack");

        // 8E1 0x3C with the parity bit forced wrong.
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, s0);
        model_load(8'h3C, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check_state("par");
        do_ack();

        // Stop bit low then a break of three more bit times.
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, s0);
        exp_ferr++;
        rx = 1'b0;
        repeat (3*OS) @(negedge clk);
        check("brk_busy_low", 32'(busy), 1);
        check_state("brk");
        rx = 1'b1;
        repeat (8) @(negedge clk);
        check("brk_busy_released", 32'(busy), 0);
        check("brk_ferr_once", ferr_cnt, exp_ferr);

        // Short low glitch from idle, then a real frame.
        rx = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy_rise", 32'(busy), 1);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_busy_drop", 32'(busy), 0);
        check_state("glitch");
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s0);
        model_load(8'h81, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check_state("f81");
        do_ack();

        // Back-to-back frames with no ack: overrun.
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s0);
        model_load(8'h11, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s1);
        model_load(8'h22, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check_state("ovr");
        do_ack();
        repeat (10) @(negedge clk);

        // Back-to-back again, acking exactly in the second frame's load cycle.
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s0);
        model_load(8'h11, 1'b0, 1'b0);
        lat1 = rise_cyc - s0;
        fork
            send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s2v);
            begin
                repeat (lat1 - 1) @(negedge clk);
                check("ackload_pre_valid", 32'(rx_valid), 1);
                check("ackload_pre_data", 32'(rx_data), 'h11);
                rx_ack = 1'b1;
                @(negedge clk);
                rx_ack = 1'b0;
                check("ackload_post_valid", 32'(rx_valid), 1);
                check("ackload_post_data", 32'(rx_data), 'h22);
            end
        join
        model_load(8'h22, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check_state("ackload");

        // Reset during data bit 4 of 0xFF while the holding register is full.
        rx = 1'b0;
        repeat (OS) @(negedge clk);
        rx = 1'b1;
        repeat (4*OS + 8) @(negedge clk);
        check("rstmid_busy", 32'(busy), 1);
        arst = 1'b1;
        #1;
        check_reset_outputs("rstmid");
        exp_q.delete();
        model_data = '0;
        @(negedge clk);
        @(negedge clk);
        arst = 1'b0;
        repeat (40) @(negedge clk);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s0);
        model_load(8'h0F, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check_state("f0f");
        do_ack();

        // Random data and frame formats.
        for (int k = 0; k < 8; k++) begin
            d   = 8'($urandom_range(0, 255));
            pe  = 1'($urandom_range(0, 1));
            po  = 1'($urandom_range(0, 1));
            st2 = 1'($urandom_range(0, 1));
            bp  = pe & 1'($urandom_range(0, 1));
            send_frame(d, pe, po, st2, bp, 1'b0, s0);
            model_load(d, bp, 1'b0);
            repeat (4) @(negedge clk);
            check_state($sformatf("rnd%0d", k));
            do_ack();
            check($sformatf("rnd%0d_ack_valid", k), 32'(rx_valid), 0);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
